// File: rtl/kbd_pkg.sv
// ============================================================================
// Module : kbd_pkg
// Shared scan-code constants and FSM encoding for the keyboard history stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package kbd_pkg;

   typedef logic [1:0] kbd_state_t;

   localparam kbd_state_t S_IDLE      = 2'd0;
   localparam kbd_state_t S_BREAK     = 2'd1;
   localparam kbd_state_t S_EXT       = 2'd2;
   localparam kbd_state_t S_EXT_BREAK = 2'd3;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   localparam logic [7:0] LETTER_LO = 8'h61;
   localparam logic [7:0] LETTER_HI = 8'h7A;

   function automatic logic is_lower_letter(input logic [7:0] a);
      return (a >= LETTER_LO) && (a <= LETTER_HI);
   endfunction

endpackage

`default_nettype wire

// File: rtl/hex7seg.sv
// ============================================================================
// Module : hex7seg
// One hex nibble to seven segments (bit 0 = a .. bit 6 = g), with blanking.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hex7seg #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] i_nibble,
   input  logic       i_blank,
   output logic [6:0] o_seg
);

   logic [6:0] w_lit;

   always_comb begin
      w_lit = 7'h00;
      if (!i_blank) begin
         case (i_nibble)
            4'h0: w_lit = 7'h3F;
            4'h1: w_lit = 7'h06;
            4'h2: w_lit = 7'h5B;
            4'h3: w_lit = 7'h4F;
            4'h4: w_lit = 7'h66;
            4'h5: w_lit = 7'h6D;
            4'h6: w_lit = 7'h7D;
            4'h7: w_lit = 7'h07;
            4'h8: w_lit = 7'h7F;
            4'h9: w_lit = 7'h6F;
            4'hA: w_lit = 7'h77;
            4'hB: w_lit = 7'h7C;
            4'hC: w_lit = 7'h39;
            4'hD: w_lit = 7'h5E;
            4'hE: w_lit = 7'h79;
            default: w_lit = 7'h71;
         endcase
      end
   end

   assign o_seg = ACTIVE_LOW ? ~w_lit : w_lit;

endmodule

`default_nettype wire

// File: rtl/kbd_ascii_history.sv
// ============================================================================
// Module : kbd_ascii_history
// PS/2 scan-code decoder with shift/caps tracking, ASCII history and hex display.
// Optional caps lock support: define KBD_ASCII_CAPS_LOCK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module kbd_ascii_history
   import kbd_pkg::*;
#(
   parameter int NUM_CHARS      = 2,
   parameter int CNT_W          = 8,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            code_in,
   input  logic                  code_valid,
   output logic [7:0]            lut_addr,
   input  logic [7:0]            ascii_norm,
   input  logic [7:0]            ascii_shift,
   output logic                  key_held,
   output logic                  shift_on,
   output logic                  caps_on,
   output logic [CNT_W-1:0]      key_count,
   output logic [14*NUM_CHARS-1:0] hex_out
);

   localparam bit              c_act_low = (SEG_ACTIVE_LOW != 0);
   localparam logic [CNT_W-1:0] c_one    = {{(CNT_W-1){1'b0}}, 1'b1};

   kbd_state_t       r_state;
   kbd_state_t       w_state_nxt;
   logic             w_do_make;
   logic             w_do_break;

   logic [7:0]       r_hist [NUM_CHARS];
   logic [7:0]       r_held_code;
   logic             r_key_held;
   logic             r_shift_l;
   logic             r_shift_r;
   logic [CNT_W-1:0] r_key_count;

   logic             w_is_lshift;
   logic             w_is_rshift;
   logic             w_is_caps;
   logic             w_repeat;
   logic             w_new_key;
   logic             w_caps_letter;
   logic [7:0]       w_ascii_sel;

   assign lut_addr = code_in;

   // ------------------------------------------------------------------------
   // Prefix FSM: state register / next state / action decode
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (code_valid) begin
         case (r_state)
            S_IDLE: begin
               if (code_in == SC_BREAK)    w_state_nxt = S_BREAK;
               else if (code_in == SC_EXT) w_state_nxt = S_EXT;
               else                        w_state_nxt = S_IDLE;
            end
            S_EXT:   w_state_nxt = (code_in == SC_BREAK) ? S_EXT_BREAK : S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_do_make  = 1'b0;
      w_do_break = 1'b0;
      if (code_valid) begin
         case (r_state)
            S_IDLE:  w_do_make  = (code_in != SC_BREAK) && (code_in != SC_EXT);
            S_BREAK: w_do_break = 1'b1;
            default: begin
               w_do_make  = 1'b0;
               w_do_break = 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Modifier / key decode and ASCII selection
   // ------------------------------------------------------------------------
   assign w_is_lshift = (code_in == SC_LSHIFT);
   assign w_is_rshift = (code_in == SC_RSHIFT);
   assign w_repeat    = r_key_held && (code_in == r_held_code);
   assign w_new_key   = w_do_make && !w_is_lshift && !w_is_rshift && !w_is_caps && !w_repeat;

   assign shift_on      = r_shift_l | r_shift_r;
   assign w_caps_letter = caps_on && is_lower_letter(ascii_norm);
   assign w_ascii_sel   = (shift_on ^ w_caps_letter) ? ascii_shift : ascii_norm;

`ifdef KBD_ASCII_CAPS_LOCK_EN
   logic r_caps_on;
   logic r_caps_down;

   assign w_is_caps = (code_in == SC_CAPS);
   assign caps_on   = r_caps_on;

   // The caps key toggles only on its first make; typematic repeats are absorbed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_caps_on   <= 1'b0;
         r_caps_down <= 1'b0;
      end else if (w_do_make && w_is_caps) begin
         r_caps_down <= 1'b1;
         if (!r_caps_down) r_caps_on <= ~r_caps_on;
      end else if (w_do_break && w_is_caps) begin
         r_caps_down <= 1'b0;
      end
   end
`else
   assign w_is_caps = 1'b0;
   assign caps_on   = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Key state, modifiers, counter and history
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_held_code <= 8'h00;
         r_key_held  <= 1'b0;
         r_shift_l   <= 1'b0;
         r_shift_r   <= 1'b0;
         r_key_count <= '0;
         for (int i = 0; i < NUM_CHARS; i++) r_hist[i] <= 8'h00;
      end else begin
         if (w_do_make && w_is_lshift) r_shift_l <= 1'b1;
         if (w_do_make && w_is_rshift) r_shift_r <= 1'b1;
         if (w_do_break && w_is_lshift) r_shift_l <= 1'b0;
         if (w_do_break && w_is_rshift) r_shift_r <= 1'b0;
         if (w_do_break && r_key_held && (code_in == r_held_code)) r_key_held <= 1'b0;
         if (w_new_key) begin
            r_held_code <= code_in;
            r_key_held  <= 1'b1;
            r_key_count <= r_key_count + c_one;
            for (int i = NUM_CHARS - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
            r_hist[0] <= w_ascii_sel;
         end
      end
   end

   assign key_held  = r_key_held;
   assign key_count = r_key_count;

   // ------------------------------------------------------------------------
   // Display: two digits per character, low nibble in the lower 7 bits
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CHARS; gi++) begin : g_char
         logic w_blank;
         if (gi == 0) begin : g_newest
            assign w_blank = ~r_key_held;
         end else begin : g_older
            assign w_blank = (r_hist[gi] == 8'h00);
         end

         hex7seg #(.ACTIVE_LOW(c_act_low)) u_lo (
            .i_nibble (r_hist[gi][3:0]),
            .i_blank  (w_blank),
            .o_seg    (hex_out[14*gi +: 7])
         );

         hex7seg #(.ACTIVE_LOW(c_act_low)) u_hi (
            .i_nibble (r_hist[gi][7:4]),
            .i_blank  (w_blank),
            .o_seg    (hex_out[14*gi+7 +: 7])
         );
      end
   endgenerate

endmodule

`default_nettype wire
